// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results and aligned/extended loads to the register file.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [4:0]  i_rd,
   input  logic        i_rf_wr,
   input  logic        i_is_load,
   input  logic [1:0]  i_ld_unit,
   input  logic        i_ld_unsigned,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_alu_result,
   input  logic        i_dm_rvalid,
   input  logic [31:0] i_dm_rdata,
   output logic        o_rf_wen,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_fwd_valid,
   output logic [4:0]  o_fwd_rd,
   output logic [31:0] o_fwd_data,
   output logic        o_misalign
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0] o_retire_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT_LD, COMMIT} state_t;

   state_t      state;
   logic [4:0]  cap_rd;
   logic        cap_rf_wr;
   logic [1:0]  cap_unit;
   logic        cap_unsigned;
   logic [1:0]  cap_addr_lo;
   logic        mis_in;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_data;

   assign o_ready     = (state != WAIT_LD);
   assign o_fwd_valid = o_rf_wen;
   assign o_fwd_rd    = o_rf_waddr;
   assign o_fwd_data  = o_rf_wdata;

   always_comb begin
      mis_in = 1'b0;
      if (i_is_load) begin
         case (i_ld_unit)
            2'b01:   mis_in = i_addr_lo[0];
            2'b10:   mis_in = (i_addr_lo != 2'b00);
            2'b11:   mis_in = 1'b1;
            default: mis_in = 1'b0;
         endcase
      end
   end

   always_comb begin
      byte_sel = i_dm_rdata[{cap_addr_lo, 3'b000} +: 8];
      half_sel = i_dm_rdata[{cap_addr_lo[1], 4'b0000} +: 16];
      case (cap_unit)
         2'b00:   ld_data = {{24{~cap_unsigned & byte_sel[7]}}, byte_sel};
         2'b01:   ld_data = {{16{~cap_unsigned & half_sel[15]}}, half_sel};
         default: ld_data = i_dm_rdata;
      endcase
   end

   // Outputs are loaded on the edge entering COMMIT, so a capture made while
   // committing only affects the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         o_rf_wen     <= 1'b0;
         o_rf_waddr   <= '0;
         o_rf_wdata   <= '0;
         o_misalign   <= 1'b0;
         cap_rd       <= '0;
         cap_rf_wr    <= 1'b0;
         cap_unit     <= '0;
         cap_unsigned <= 1'b0;
         cap_addr_lo  <= '0;
      end else begin
         o_rf_wen   <= 1'b0;
         o_misalign <= 1'b0;
         case (state)
            IDLE, COMMIT: begin
               if (i_valid) begin
                  if (i_is_load && !mis_in) begin
                     state        <= WAIT_LD;
                     cap_rd       <= i_rd;
                     cap_rf_wr    <= i_rf_wr;
                     cap_unit     <= i_ld_unit;
                     cap_unsigned <= i_ld_unsigned;
                     cap_addr_lo  <= i_addr_lo;
                  end else begin
                     state      <= COMMIT;
                     o_rf_waddr <= i_rd;
                     o_misalign <= mis_in;
                     o_rf_wen   <= i_rf_wr && (i_rd != 5'd0) && !mis_in;
                     if (!i_is_load)
                        o_rf_wdata <= i_alu_result;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_LD: begin
               if (i_dm_rvalid) begin
                  state      <= COMMIT;
                  o_rf_waddr <= cap_rd;
                  o_rf_wdata <= ld_data;
                  o_rf_wen   <= cap_rf_wr && (cap_rd != 5'd0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         o_retire_cnt <= '0;
      else if (state == COMMIT)
         o_retire_cnt <= o_retire_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [4:0]  i_rd;
   logic        i_rf_wr;
   logic        i_is_load;
   logic [1:0]  i_ld_unit;
   logic        i_ld_unsigned;
   logic [1:0]  i_addr_lo;
   logic [31:0] i_alu_result;
   logic        i_dm_rvalid;
   logic [31:0] i_dm_rdata;
   logic        o_rf_wen;
   logic [4:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;
   logic        o_fwd_valid;
   logic [4:0]  o_fwd_rd;
   logic [31:0] o_fwd_data;
   logic        o_misalign;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] o_retire_cnt;
`endif

   wb_stage dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_rd(i_rd), .i_rf_wr(i_rf_wr), .i_is_load(i_is_load),
      .i_ld_unit(i_ld_unit), .i_ld_unsigned(i_ld_unsigned), .i_addr_lo(i_addr_lo),
      .i_alu_result(i_alu_result), .i_dm_rvalid(i_dm_rvalid), .i_dm_rdata(i_dm_rdata),
      .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data),
      .o_misalign(o_misalign)
`ifdef WB_RETIRE_CNT_EN
      , .o_retire_cnt(o_retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // reference model: one outstanding load slot plus the value visible at the write port
   bit          m_waiting = 0;
   bit          m_commit = 0;
   bit          m_wen = 0;
   bit          m_mis = 0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_cnt = '0;
   logic [4:0]  s_rd;
   bit          s_wr;
   int          s_unit;
   bit          s_uns;
   int          s_addr;

   function automatic logic [31:0] load_value(logic [31:0] word, int unit, bit uns, int addr);
      logic [31:0] v;
      if (unit == 0) begin
         v = (word >> (8 * addr)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (unit == 1) begin
         v = (word >> (16 * (addr / 2))) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic bit is_misaligned(int unit, int addr);
      return (unit == 3) || (unit == 1 && (addr % 2) != 0) || (unit == 2 && addr != 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [4:0] rd, input bit wr, input bit ld,
                        input logic [1:0] unit, input bit uns, input logic [1:0] addr,
                        input logic [31:0] alu, input bit rv, input logic [31:0] rdata);
      i_valid = v; i_rd = rd; i_rf_wr = wr; i_is_load = ld; i_ld_unit = unit;
      i_ld_unsigned = uns; i_addr_lo = addr; i_alu_result = alu;
      i_dm_rvalid = rv; i_dm_rdata = rdata;
   endtask

   task automatic idle_in();
      drive(0, 5'd0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 0, 32'h0);
   endtask

   // advance one clock: update the model from the current inputs, then check all outputs
   task automatic tick();
      bit n_commit;
      n_commit = 0;
      m_wen = 0;
      m_mis = 0;
      if (rst) begin
         m_waiting = 0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
      end else begin
         if (m_commit) m_cnt = m_cnt + 1;
         if (m_waiting) begin
            if (i_dm_rvalid) begin
               n_commit = 1; m_waiting = 0;
               m_wen = s_wr && s_rd != 0;
               m_waddr = s_rd;
               m_wdata = load_value(i_dm_rdata, s_unit, s_uns, s_addr);
            end
         end else if (i_valid) begin
            if (i_is_load && !is_misaligned(int'(i_ld_unit), int'(i_addr_lo))) begin
               m_waiting = 1;
               s_rd = i_rd; s_wr = i_rf_wr; s_unit = int'(i_ld_unit);
               s_uns = i_ld_unsigned; s_addr = int'(i_addr_lo);
            end else begin
               n_commit = 1;
               m_waddr = i_rd;
               m_mis = i_is_load;
               m_wen = i_rf_wr && i_rd != 0 && !i_is_load;
               if (!i_is_load) m_wdata = i_alu_result;
            end
         end
      end
      m_commit = n_commit;
      @(posedge clk);
      #1;
      chk("ready", 32'(o_ready), 32'(!m_waiting));
      chk("rf_wen", 32'(o_rf_wen), 32'(m_wen));
      chk("misalign", 32'(o_misalign), 32'(m_mis));
      chk("rf_wdata", o_rf_wdata, m_wdata);
      chk("fwd_valid", 32'(o_fwd_valid), 32'(m_wen));
      chk("fwd_data", o_fwd_data, m_wdata);
      if (m_wen || rst) begin
         chk("rf_waddr", 32'(o_rf_waddr), 32'(m_waddr));
         chk("fwd_rd", 32'(o_fwd_rd), 32'(m_waddr));
      end
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", o_retire_cnt, m_cnt);
`endif
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      tick(); tick();
      chk("reset_wen", 32'(o_rf_wen), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) tick();

      // non-load rd=5 commits exactly one cycle later
      drive(1, 5'd5, 1, 0, 2'd0, 0, 2'd0, 32'h1234_5678, 0, 32'h0);
      tick();
      chk("nl_wdata", o_rf_wdata, 32'h1234_5678);
      idle_in(); tick();
      chk("nl_once", 32'(o_rf_wen), 32'h0);

      // signed byte load, rvalid 4 cycles after accept
      drive(1, 5'd7, 1, 1, 2'd0, 0, 2'd3, 32'hDEAD_BEEF, 0, 32'h0);
      tick();
      idle_in();
      for (int i = 0; i < 3; i++) tick();
      drive(0, 5'd0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 1, 32'h80FF_0000);
      tick();
      chk("sb_wdata", o_rf_wdata, 32'hFFFF_FF80);
      idle_in(); tick();

      // unsigned half load at addr 2
      drive(1, 5'd9, 1, 1, 2'd1, 1, 2'd2, 32'h0, 0, 32'h0);
      tick();
      drive(0, 5'd0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 1, 32'hBEEF_1234);
      tick();
      chk("uh_wdata", o_rf_wdata, 32'h0000_BEEF);

      // misaligned word load goes straight to commit
      drive(1, 5'd4, 1, 1, 2'd2, 0, 2'd1, 32'h0, 0, 32'h0);
      tick();
      chk("mis_pulse", 32'(o_misalign), 32'h1);
      idle_in(); tick();

      // back-to-back non-loads rd=1,2,0
      for (int i = 0; i < 3; i++) begin
         drive(1, (i == 2) ? 5'd0 : 5'(i + 1), 1, 0, 2'd0, 0, 2'd0, 32'hA0 + 32'(i), 0, 32'h0);
         tick();
      end
      idle_in(); tick();

      // reset aborts WAIT_LD; later rvalid must be ignored
      drive(1, 5'd3, 1, 1, 2'd2, 0, 2'd0, 32'h0, 0, 32'h0);
      tick();
      idle_in(); rst = 1'b1; tick();
      rst = 1'b0;
      drive(0, 5'd0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 1, 32'h5555_AAAA);
      tick();
      idle_in(); tick();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 9) < 3, $urandom);
         tick();
      end
      rst = 1'b0;
      idle_in(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
